pipe_ctrl: RTL

Central stall/flush sequencer for the five-stage pipeline. It drives per-register hold (stall) and bubble-insert (flush) controls into the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. It resolves three hazard sources:

- multi-cycle data-memory waits, tracked by a timeout state machine;
- taken branches resolved in EX;
- load-use RAW hazards between EX and ID.

It also keeps a saturating stall-cycle performance counter.

---
 rtl/pipe_ctrl.sv | 112 +++++++++++
 1 files changed

// File: rtl/pipe_ctrl.sv
// Stall/flush sequencer for the five-stage pipeline: data-memory wait timeout FSM,
// taken-branch squash, load-use bubble insertion and a saturating stall-cycle counter.
module pipe_ctrl #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_rs_re,
  input  logic [4:0]  id_rs_addr,
  input  logic        id_rt_re,
  input  logic [4:0]  id_rt_addr,
  input  logic        ex_is_load,
  input  logic        ex_regfile_we,
  input  logic [4:0]  ex_regfile_addr,
  input  logic        ex_branch_taken,
  input  logic        mem_req,
  input  logic        mem_ack,
  output logic [4:0]  stall,
  output logic [4:0]  flush,
  output logic        mem_err,
  output logic [31:0] perf_stall_cnt,
  output logic        o_dbg_state
);

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_MEM_WAIT = 1'b1
  } state_t;

  localparam logic [7:0] TMO = 8'(MEM_TIMEOUT);

  state_t      r_state;
  logic [7:0]  r_cnt;
  logic [31:0] r_perf;

  logic        w_lu;
  logic        w_timeout;
  logic        w_mw;
  logic [4:0]  w_stall;
  logic [4:0]  w_flush;

  // Handshake: mem_req is held by MEM for the whole access; the access completes
  // in the cycle where mem_req && mem_ack, and dropping mem_req abandons it.
  always_comb begin
    w_lu = ex_is_load && ex_regfile_we && (ex_regfile_addr != 5'd0) &&
           ((id_rs_re && (id_rs_addr == ex_regfile_addr)) ||
            (id_rt_re && (id_rt_addr == ex_regfile_addr)));
    w_timeout = (r_state == ST_MEM_WAIT) && mem_req && !mem_ack && (r_cnt == TMO);
    w_mw      = mem_req && !mem_ack && !w_timeout;
  end

  // Held branch/lu hazards simply stay visible on the inputs until mw clears.
  always_comb begin
    w_stall = 5'b00000;
    w_flush = 5'b00000;
    if (w_mw) begin
      w_stall = 5'b01111;
      w_flush = 5'b10000;
    end else if (ex_branch_taken) begin
      w_flush = 5'b00110;
    end else if (w_lu) begin
      w_stall = 5'b00011;
      w_flush = 5'b00100;
    end
    if (w_timeout) begin
      w_flush[4] = 1'b1;
    end
  end

  always_comb begin
    stall          = rst ? 5'b00000 : w_stall;
    flush          = rst ? 5'b00000 : w_flush;
    mem_err        = rst ? 1'b0 : w_timeout;
    perf_stall_cnt = rst ? 32'd0 : r_perf;
    o_dbg_state    = r_state;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_RUN;
      r_cnt   <= 8'd0;
      r_perf  <= 32'd0;
    end else begin
      if (w_stall[0] && (r_perf != 32'hFFFF_FFFF)) begin
        r_perf <= r_perf + 32'd1;
      end
      case (r_state)
        ST_RUN: begin
          if (mem_req && !mem_ack) begin
            r_state <= ST_MEM_WAIT;
            r_cnt   <= 8'd1;
          end else begin
            r_cnt   <= 8'd0;
          end
        end
        ST_MEM_WAIT: begin
          if (mem_ack || !mem_req || w_timeout) begin
            r_state <= ST_RUN;
            r_cnt   <= 8'd0;
          end else begin
            r_cnt   <= r_cnt + 8'd1;
          end
        end
        default: begin
          r_state <= ST_RUN;
          r_cnt   <= 8'd0;
        end
      endcase
    end
  end

endmodule
